// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 1-Wire controller blocks.
package dht11_pkg;
   localparam int DELAY_W = 9;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; clear parks it at zero.
module tick_prescaler #(
   parameter int TICK_DIV = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);
   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] pre;

   assign tick = (pre == PRE_TC);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre <= '0;
      end else if (clear || tick) begin
         pre <= '0;
      end else begin
         pre <= pre + 1'b1;
      end
   end
endmodule

// File: rtl/delay_module.sv
// Auto-reloading delay timer: one-cycle out_delay strobe every `delay` ticks, 0 disables.
//  state | meaning
//  IDLE  | latch delay each cycle, start counting once it is non-zero
//  RUN   | count ticks up to dl-1, strobe and reload at terminal
module delay_module
   import dht11_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DELAY_W-1:0] delay,
   output logic               out_delay
);
   state_t             state;
   logic [DELAY_W-1:0] cnt;
   logic [DELAY_W-1:0] dl;
   logic               tick;
   logic               idle;

   assign idle = (state == IDLE);

   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (idle),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         dl        <= '0;
         out_delay <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               dl        <= delay;
               cnt       <= '0;
               out_delay <= 1'b0;
               if (delay != '0) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (tick) begin
                  // dl is never 0 in RUN, so dl-1 cannot underflow
                  if (cnt == dl - 1'b1) begin
                     out_delay <= 1'b1;
                     cnt       <= '0;
                     dl        <= delay;
                     if (delay == '0) begin
                        state <= IDLE;
                     end
                  end else begin
                     cnt       <= cnt + 1'b1;
                     out_delay <= 1'b0;
                  end
               end else begin
                  out_delay <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_delay <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_delay_module.sv
// Self-checking bench for delay_module at TICK_DIV=1 and TICK_DIV=4.
module tb_delay_module;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [8:0] delay1 = '0;
   logic [8:0] delay4 = '0;
   logic       out1;
   logic       out4;
   int         checks = 0;
   int         failures = 0;

   delay_module #(.TICK_DIV(1)) dut (
      .clk       (clk),
      .rst       (rst),
      .delay     (delay1),
      .out_delay (out1)
   );

   delay_module #(.TICK_DIV(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .delay     (delay4),
      .out_delay (out4)
   );

   always #5 clk = ~clk;

   typedef struct {
      int d;
      int first1;
      int per1;
      int first4;
      int per4;
   } vec_t;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: out_delay=%0b expected=%0b at t=%0t", name, act, exp, $time);
      end
   endtask

   // Hold reset for one cycle with new delay values, release on a falling edge
   task automatic restart(input int d1, input int d4);
      @(negedge clk);
      rst    = 1'b0;
      delay1 = 9'(d1);
      delay4 = 9'(d4);
      #1;
      check("reset_out1", out1, 1'b0);
      check("reset_out4", out4, 1'b0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Reference: remaining clock cycles until the next strobe
   task automatic model_edge(inout bit run, inout int rem, input int d, input int td,
                             output bit o);
      o = 1'b0;
      if (!run) begin
         if (d != 0) begin
            run = 1'b1;
            rem = d * td;
         end
      end else begin
         rem--;
         if (rem == 0) begin
            o = 1'b1;
            if (d == 0) run = 1'b0;
            else rem = d * td;
         end
      end
   endtask

   initial begin
      vec_t vecs[6];
      bit   run1, run4, e1, e4;
      int   rem1, rem4;

      vecs[0] = '{d: 6,   first1: 7,   per1: 6,   first4: 25,   per4: 24};
      vecs[1] = '{d: 1,   first1: 2,   per1: 1,   first4: 5,    per4: 4};
      vecs[2] = '{d: 0,   first1: 0,   per1: 0,   first4: 0,    per4: 0};
      vecs[3] = '{d: 2,   first1: 3,   per1: 2,   first4: 9,    per4: 8};
      vecs[4] = '{d: 9,   first1: 10,  per1: 9,   first4: 37,   per4: 36};
      vecs[5] = '{d: 511, first1: 512, per1: 511, first4: 2045, per4: 2044};

      #1;
      check("por_out1", out1, 1'b0);
      check("por_out4", out4, 1'b0);

      foreach (vecs[i]) begin
         int n;
         n = (vecs[i].per4 != 0) ? vecs[i].first4 + 2 * vecs[i].per4 + 2 : 60;
         restart(vecs[i].d, vecs[i].d);
         for (int k = 1; k <= n; k++) begin
            bit x1, x4;
            @(posedge clk);
            #1;
            x1 = (vecs[i].per1 != 0) && (k >= vecs[i].first1) &&
                 ((k - vecs[i].first1) % vecs[i].per1 == 0);
            x4 = (vecs[i].per4 != 0) && (k >= vecs[i].first4) &&
                 ((k - vecs[i].first4) % vecs[i].per4 == 0);
            check($sformatf("vec%0d_d%0d_td1_E%0d", i, vecs[i].d, k), out1, x1);
            check($sformatf("vec%0d_d%0d_td4_E%0d", i, vecs[i].d, k), out4, x4);
         end
      end

      // delay 6 -> 3 two cycles after the E7 strobe: E13 keeps period 6, then every 3
      restart(6, 0);
      for (int k = 1; k <= 23; k++) begin
         bit x;
         @(posedge clk);
         #1;
         x = (k == 7) || (k == 13) || (k == 16) || (k == 19) || (k == 22);
         check($sformatf("change_E%0d", k), out1, x);
         if (k == 9) begin
            @(negedge clk);
            delay1 = 9'd3;
         end
      end

      // Reset mid-count at cnt=3, then the first strobe must again follow E7
      restart(6, 6);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midreset_out1", out1, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("after_midreset_E%0d", k), out1, (k == 7) || (k == 13));
      end

      // Reset while the strobe is high must clear it without a clock edge
      restart(1, 1);
      repeat (3) @(posedge clk);
      #1;
      check("d1_high_before_reset", out1, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check("async_clear_out1", out1, 1'b0);

      // Randomized run against the reference model, with occasional resets
      @(negedge clk);
      rst    = 1'b0;
      delay1 = 9'd0;
      delay4 = 9'd0;
      run1 = 0; run4 = 0; rem1 = 0; rem4 = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 19) == 0)
            delay1 = 9'($urandom_range(0, 3) == 0 ? $urandom_range(0, 40) : $urandom_range(0, 8));
         if ($urandom_range(0, 29) == 0)
            delay4 = 9'($urandom_range(0, 6));
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b0;
            run1 = 0; run4 = 0;
            #1;
            check("rand_reset_out1", out1, 1'b0);
            check("rand_reset_out4", out4, 1'b0);
            @(negedge clk);
            rst = 1'b1;
         end
         @(posedge clk);
         model_edge(run1, rem1, int'(delay1), 1, e1);
         model_edge(run4, rem4, int'(delay4), 4, e4);
         #1;
         check($sformatf("rand_td1_c%0d", c), out1, e1);
         check($sformatf("rand_td4_c%0d", c), out4, e4);
         @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/delay_module.md
# delay_module

Programmable periodic delay timer for the DHT11 1-Wire controller. Counts `delay` time ticks and then emits a one-clock `out_delay` strobe. It reloads automatically, so the strobe repeats every `delay` ticks. The protocol FSM uses the strobe to time bus phases: start-pulse low time, response windows and bit sampling points.

## Interface
- `TICK_DIV`, default 1: clock cycles per time tick. The prescaler divides `clk` by this value; the minimum is 1. With a 1 MHz clock and 1, one tick is 1 µs.
- `clk`, input, 1 bit: single clock, rising-edge.
- `rst`, input, 1 bit: reset, asynchronous and active-low (0 = reset).
- `delay`, input, 9 bits: delay length in ticks, unsigned, 0–511. The value 0 disables the timer.
- `out_delay`, output, 1 bit: registered strobe, high for exactly one `clk` cycle at each expiry.

## Operation
- FSM states are IDLE and RUN.
- While reset is asserted (`rst`=0):
  - state = IDLE
  - tick counter `cnt` = 0
  - prescaler `pre` = 0
  - latched delay `dl` = 0
  - `out_delay` = 0
- In IDLE, on each rising edge:
  - `dl` <= `delay`, `cnt` <= 0, `pre` <= 0.
  - If `delay` != 0, go to RUN; otherwise stay in IDLE.
  - `out_delay` stays 0.
- Prescaler in RUN:
  - `tick` is asserted when `pre` == TICK_DIV-1. When `tick` is asserted, `pre` wraps to 0; otherwise `pre` increments.
  - With TICK_DIV=1, `tick` is asserted every cycle.
- Counting in RUN, on a `tick` cycle:
  - If `cnt` == `dl`-1 (terminal): `out_delay` <= 1, `cnt` <= 0, and `dl` <= `delay` (the new value is sampled here).
  - If the sampled `delay` is 0 at terminal, go to IDLE.
  - Otherwise: `cnt` <= `cnt`+1 and `out_delay` <= 0.
- On a non-`tick` cycle in RUN, `out_delay` <= 0 and `cnt` holds.
- Changes to `delay` during a count are ignored until the next terminal or IDLE cycle. There is no glitch and the period is never truncated.
- `dl`=1 with TICK_DIV=1 gives a terminal every cycle, so `out_delay` is held high continuously.
- Width rules:
  - `cnt` and `dl` are 9 bits.
  - `pre` is clog2(TICK_DIV) bits, minimum 1.
  - Comparisons are unsigned.
  - `cnt` never exceeds `dl`-1, so no wrap-around beyond 511.
- Reset asserted mid-count immediately clears all state. After release, counting restarts from IDLE.

## Timing
- Edge numbering starts at E1, the first rising edge after `rst` rises.
- E1: IDLE latches `delay` = D and enters RUN.
- With TICK_DIV=1:
  - `out_delay` first rises after edge E(1+D) and is high for one cycle.
  - Subsequent strobes follow every D cycles: after E(1+2D), E(1+3D), and so on.
- General case: the first strobe follows E(1+D·TICK_DIV), and the period is D·TICK_DIV cycles.
- The output is fully registered; there is no combinational path from `delay` to `out_delay`.

## Structure
- Shared package (`dht11_pkg`) holds:
  - the FSM state encoding (IDLE, RUN)
  - `DELAY_W` = 9
- One natural sub-module, `tick_prescaler`:
  - inputs: `clk`, `rst`, clear
  - output: `tick`
  - parameter: TICK_DIV
  - The rest of the design is one FSM plus the counter.

## Test plan
- `delay`=6, TICK_DIV=1, hold `rst`=0 for 1 cycle then release: `out_delay` is 0 during reset and until E7. It is a single-cycle high after E7, E13, E19; verify the 6-cycle period over 1000 cycles.
- `delay`=1: `out_delay` is high continuously from after E2 onward. `delay`=0: `out_delay` stays 0 forever and the state stays IDLE.
- Change `delay` from 6 to 3 two cycles after a strobe: the current period is still 6. The following periods are 3.
- Assert `rst`=0 mid-count (cnt=3): `out_delay` goes 0 immediately and asynchronously. After release, the first strobe follows E7 again.
- `delay`=511: strobes are exactly 511 cycles apart, with no overflow.
- TICK_DIV=4, `delay`=6: the first strobe follows E25 and the period is 24 cycles; the strobe width is still one `clk` cycle.
